// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiplier sequencer for MULT/MULTU.
// Drives one external WIDTH-bit adder every busy cycle. Signed ops take the
// operand magnitudes, multiply unsigned, then negate the 2*WIDTH product if
// the operand signs differ.
//
// Ports:
//   CLK, RESETN          clock, asynchronous active-low reset
//   START, CANCEL        begin op (sampled in IDLE) / abort op in progress
//   SIGNED_I, OP_A, OP_B signed-mode flag and operands, sampled with START
//   BUSY, DONE           op in progress / one-cycle result-valid pulse
//   RESULT_HI/LO         product halves, held until the next DONE
//   ADD_A/ADD_B/ADD_CIN  external adder operands (combinational from state)
//   ADD_SUM/ADD_COUT     external adder result, same cycle
//
// Build option: define MUL_EARLY_TERM_EN to leave ITER as soon as the
// remaining multiplier bits are all zero.
module mul_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             CANCEL,
    input  logic             SIGNED_I,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic [WIDTH-1:0] RESULT_LO,
    output logic [WIDTH-1:0] ADD_A,
    output logic [WIDTH-1:0] ADD_B,
    output logic             ADD_CIN,
    input  logic [WIDTH-1:0] ADD_SUM,
    input  logic             ADD_COUT
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABS_A  = 3'd1;
    localparam logic [2:0] S_ABS_B  = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_NEG_LO = 3'd4;
    localparam logic [2:0] S_NEG_HI = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   add_a_c;
    logic [WIDTH-1:0]   add_b_c;
    logic               add_cin_c;
    logic               collapse_c;
    logic [2*WIDTH-1:0] early_prod_c;

    // Early termination: the unconsumed multiplier bits sit in LO[W-1-k:0];
    // once they are all zero the remaining iterations would only shift.
`ifdef MUL_EARLY_TERM_EN
    logic [CW:0] shamt_c;
    always_comb begin
        shamt_c      = (CW+1)'(WIDTH) - (CW+1)'(cnt_q);
        collapse_c   = (WIDTH'(lo_q << cnt_q) == '0);
        early_prod_c = {hi_q, lo_q} >> shamt_c;
    end
`else
    always_comb begin
        collapse_c   = 1'b0;
        early_prod_c = '0;
    end
`endif

    // Next-state, datapath and adder-drive logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        carry_d   = carry_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        add_a_c   = '0;
        add_b_c   = '0;
        add_cin_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !CANCEL) begin
                    a_d     = OP_A;
                    lo_d    = OP_B;
                    hi_d    = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    sgn_d   = SIGNED_I;
                    neg_d   = SIGNED_I & (OP_A[WIDTH-1] ^ OP_B[WIDTH-1]);
                    state_d = SIGNED_I ? S_ABS_A : S_ITER;
                end
            end
            S_ABS_A: begin
                // Two's-complement negate via ~A + 1; -2^(W-1) maps to itself as unsigned.
                add_a_c   = a_q[WIDTH-1] ? ~a_q : a_q;
                add_cin_c = a_q[WIDTH-1];
                a_d       = ADD_SUM;
                state_d   = S_ABS_B;
            end
            S_ABS_B: begin
                add_a_c   = lo_q[WIDTH-1] ? ~lo_q : lo_q;
                add_cin_c = lo_q[WIDTH-1];
                lo_d      = ADD_SUM;
                state_d   = S_ITER;
            end
            S_ITER: begin
                if (collapse_c) begin
                    {hi_d, lo_d} = early_prod_c;
                    state_d      = sgn_q ? S_NEG_LO : S_FIN;
                end else begin
                    add_a_c      = hi_q;
                    add_b_c      = lo_q[0] ? a_q : '0;
                    {hi_d, lo_d} = {ADD_COUT, ADD_SUM, lo_q[WIDTH-1:1]};
                    cnt_d        = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = sgn_q ? S_NEG_LO : S_FIN;
                    end
                end
            end
            S_NEG_LO: begin
                add_a_c   = neg_q ? ~lo_q : lo_q;
                add_cin_c = neg_q;
                lo_d      = ADD_SUM;
                carry_d   = ADD_COUT;
                state_d   = S_NEG_HI;
            end
            S_NEG_HI: begin
                add_a_c   = neg_q ? ~hi_q : hi_q;
                add_cin_c = neg_q & carry_q;
                hi_d      = ADD_SUM;
                state_d   = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over any progress made this cycle.
        if (CANCEL && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d = S_IDLE;
        end

        // Result registers load on entry to FIN so they are valid alongside DONE.
        if ((state_d == S_FIN) && (state_q != S_FIN)) begin
            res_hi_d = hi_d;
            res_lo_d = lo_d;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            carry_q  <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            carry_q  <= carry_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESULT_HI = res_hi_q;
    assign RESULT_LO = res_lo_q;
    assign ADD_A     = add_a_c;
    assign ADD_B     = add_b_c;
    assign ADD_CIN   = add_cin_c;

endmodule
